// File: rtl/p_pkg.sv
// rtl/p_pkg.sv - shared state constants and sizing helper for the p_* blocks
//
// Contents:
//   P_ST_FILL / P_ST_HOLD : deserializer state encoding
//   p_count_width(n)      : bits needed to hold a count in the range 0..n
package p_pkg;

   localparam logic P_ST_FILL = 1'b0;
   localparam logic P_ST_HOLD = 1'b1;

   function automatic int p_count_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/p_slot_reg.sv
// rtl/p_slot_reg.sv - one output slot register with load, clear and sync reset
//
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset, forces q to 0
//   load   : capture d (wins over clear)
//   clear  : force q to 0
//   d      : word to capture
//   q      : stored word
module p_slot_reg #(
   parameter int BUS_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 clear,
   input  logic [BUS_WIDTH-1:0] d,
   output logic [BUS_WIDTH-1:0] q
);

   // Load has priority over clear so slot 0 can be refilled in the same
   // cycle the previous group leaves.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (clear) begin
         q <= '0;
      end
   end

endmodule

// File: rtl/p_deserializer.sv
// rtl/p_deserializer.sv - collects BUS_WIDTH-bit words into an NB_INS-wide group
//
// Optional feature: P_DESER_FLUSH_EN adds the flush input, which presents a
// partially filled group early.
//
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset
//   flush      : present the current partial group (P_DESER_FLUSH_EN only)
//   in_valid   : producer has a word on in_bus
//   in_ready   : word accepted this cycle
//   in_bus     : incoming word
//   out_valid  : out_buses holds a complete or flushed group
//   out_ready  : consumer takes the group this cycle
//   out_buses  : collected words, index 0 = first received
//   fill_count : number of words in the current group
module p_deserializer
   import p_pkg::*;
#(
   parameter int BUS_WIDTH = 1,
   parameter int NB_INS    = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
`ifdef P_DESER_FLUSH_EN
   input  logic                                 flush,
`endif
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [BUS_WIDTH-1:0]                 in_bus,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [BUS_WIDTH-1:0]                 out_buses [NB_INS],
   output logic [p_count_width(NB_INS)-1:0]     fill_count
);

   localparam int CW = p_count_width(NB_INS);
   localparam logic [CW-1:0] LAST_IDX = CW'(NB_INS - 1);

   logic          state_q, state_d;
   logic [CW-1:0] fill_count_q, fill_count_d;
   logic          in_hs, out_hs, flush_go;
   logic [CW-1:0] wr_idx;

   assign in_hs  = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

`ifdef P_DESER_FLUSH_EN
   // An empty group is never presented; flush while holding is meaningless.
   assign flush_go = flush & (state_q == P_ST_FILL) & (fill_count_q != '0);
`else
   assign flush_go = 1'b0;
`endif

   // When a word enters in the same cycle a group leaves, it starts the new
   // group, so it lands in slot 0 rather than at the (full) fill count.
   assign wr_idx = out_hs ? '0 : fill_count_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= P_ST_FILL;
         fill_count_q <= '0;
      end else begin
         state_q      <= state_d;
         fill_count_q <= fill_count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      fill_count_d = fill_count_q;
      if (state_q == P_ST_FILL) begin
         if (in_hs) begin
            fill_count_d = fill_count_q + CW'(1);
            if (fill_count_q == LAST_IDX) begin
               state_d = P_ST_HOLD;
            end
         end
         if (flush_go) begin
            state_d = P_ST_HOLD;
         end
      end else begin
         if (out_hs) begin
            if (in_hs) begin
               fill_count_d = CW'(1);
               // A single-slot group is already full after one word.
               state_d      = (NB_INS == 1) ? P_ST_HOLD : P_ST_FILL;
            end else begin
               fill_count_d = '0;
               state_d      = P_ST_FILL;
            end
         end
      end
   end

   // Output logic
   always_comb begin
      out_valid = (state_q == P_ST_HOLD);
      in_ready  = (state_q == P_ST_FILL) ? 1'b1 : out_ready;
   end

   assign fill_count = fill_count_q;

   for (genvar i = 0; i < NB_INS; i++) begin : g_slot
      p_slot_reg #(
         .BUS_WIDTH(BUS_WIDTH)
      ) u_slot (
         .clk   (clk),
         .reset (reset),
         .load  (in_hs && (wr_idx == CW'(i))),
         .clear (out_hs),
         .d     (in_bus),
         .q     (out_buses[i])
      );
   end

endmodule

// File: tb/tb_p_deserializer.sv
// tb/tb_p_deserializer.sv - self-checking bench for p_deserializer
module tb_p_deserializer;

   localparam int BW = 8;
   localparam int NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       flush;
   logic       iv_a, ir_a, ov_a, or_a;
   logic [7:0] bus_a;
   logic [7:0] ob_a [NB];
   logic [2:0] fc_a;
   logic       iv_b, ir_b, ov_b, or_b;
   logic [7:0] bus_b;
   logic [7:0] ob_b [1];
   logic [0:0] fc_b;

   p_deserializer #(.BUS_WIDTH(BW), .NB_INS(NB)) dut_a (
      .clk        (clk),
      .reset      (reset),
`ifdef P_DESER_FLUSH_EN
      .flush      (flush),
`endif
      .in_valid   (iv_a),
      .in_ready   (ir_a),
      .in_bus     (bus_a),
      .out_valid  (ov_a),
      .out_ready  (or_a),
      .out_buses  (ob_a),
      .fill_count (fc_a)
   );

   p_deserializer #(.BUS_WIDTH(BW), .NB_INS(1)) dut_b (
      .clk        (clk),
      .reset      (reset),
`ifdef P_DESER_FLUSH_EN
      .flush      (1'b0),
`endif
      .in_valid   (iv_b),
      .in_ready   (ir_b),
      .in_bus     (bus_b),
      .out_valid  (ov_b),
      .out_ready  (or_b),
      .out_buses  (ob_b),
      .fill_count (fc_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference model: each instance keeps the list of words of its current
   // group and a flag saying whether that group is being presented.
   logic [7:0] m_slot [2][4];
   int         m_cnt  [2];
   bit         m_pres [2];
   int         m_nb   [2] = '{4, 1};

   task automatic model_step(input int k, input bit rst, input bit iv, input logic [7:0] d,
                             input bit ordy, input bit fl);
      bit ir, acc, take, fl_eff;
      ir     = !m_pres[k] || ordy;
      acc    = iv && ir;
      take   = m_pres[k] && ordy;
      fl_eff = fl && !m_pres[k] && (m_cnt[k] > 0);
      if (rst) begin
         for (int j = 0; j < 4; j++) m_slot[k][j] = 8'h00;
         m_cnt[k]  = 0;
         m_pres[k] = 1'b0;
      end else begin
         if (take) begin
            for (int j = 0; j < 4; j++) m_slot[k][j] = 8'h00;
            m_cnt[k]  = 0;
            m_pres[k] = 1'b0;
         end
         if (acc) begin
            m_slot[k][m_cnt[k]] = d;
            m_cnt[k]++;
         end
         if (m_cnt[k] == m_nb[k] || fl_eff) m_pres[k] = 1'b1;
      end
   endtask

   logic [7:0] got [$];
   int         hs_cyc [$];

   // One clock: check combinational in_ready mid-cycle, capture departing
   // groups, advance the model at the edge and compare just after it.
   task automatic cycle();
      @(negedge clk);
      chk("in_ready_a", int'(ir_a), int'(!m_pres[0] || or_a));
      chk("in_ready_b", int'(ir_b), int'(!m_pres[1] || or_b));
      if (ov_a && or_a) begin
         for (int j = 0; j < NB; j++) got.push_back(ob_a[j]);
         hs_cyc.push_back(cyc);
      end
      @(posedge clk);
      model_step(0, reset, iv_a, bus_a, or_a, flush);
      model_step(1, reset, iv_b, bus_b, or_b, 1'b0);
      cyc++;
      #1;
      chk("model_valid_a", int'(ov_a), int'(m_pres[0]));
      chk("model_count_a", int'(fc_a), m_cnt[0]);
      for (int j = 0; j < NB; j++) chk($sformatf("model_slot_a[%0d]", j), int'(ob_a[j]), int'(m_slot[0][j]));
      chk("model_valid_b", int'(ov_b), int'(m_pres[1]));
      chk("model_count_b", int'(fc_b), m_cnt[1]);
      chk("model_slot_b", int'(ob_b[0]), int'(m_slot[1][0]));
   endtask

   function automatic logic [31:0] pack_a();
      return {ob_a[3], ob_a[2], ob_a[1], ob_a[0]};
   endfunction

   typedef struct {
      bit          rst;
      bit          iv;
      logic [7:0]  d;
      bit          ordy;
      bit          ev;
      int          ec;
      bit          eir;
      logic [31:0] eb;
   } vec_t;

   vec_t tbl [17];
   logic [7:0] sent [$];

   initial begin
      tbl[0]  = '{0, 1, 8'h11, 0, 0, 1, 1, 32'h0000_0011};
      tbl[1]  = '{0, 1, 8'h22, 0, 0, 2, 1, 32'h0000_2211};
      tbl[2]  = '{0, 1, 8'h33, 0, 0, 3, 1, 32'h0033_2211};
      tbl[3]  = '{0, 1, 8'h44, 0, 1, 4, 0, 32'h4433_2211};
      for (int i = 4; i <= 8; i++) tbl[i] = '{0, 1, 8'h55, 0, 1, 4, 0, 32'h4433_2211};
      tbl[9]  = '{0, 1, 8'h55, 1, 0, 1, 1, 32'h0000_0055};
      tbl[10] = '{0, 1, 8'h66, 0, 0, 2, 1, 32'h0000_6655};
      tbl[11] = '{1, 1, 8'h77, 0, 0, 0, 1, 32'h0000_0000};
      tbl[12] = '{0, 1, 8'hA1, 0, 0, 1, 1, 32'h0000_00A1};
      tbl[13] = '{0, 1, 8'hA2, 0, 0, 2, 1, 32'h0000_A2A1};
      tbl[14] = '{0, 1, 8'hA3, 0, 0, 3, 1, 32'h00A3_A2A1};
      tbl[15] = '{0, 1, 8'hA4, 0, 1, 4, 0, 32'hA4A3_A2A1};
      tbl[16] = '{0, 0, 8'h00, 1, 0, 0, 1, 32'h0000_0000};

      reset = 1'b1; flush = 1'b0;
      iv_a = 1'b0; or_a = 1'b0; bus_a = 8'h00;
      iv_b = 1'b0; or_b = 1'b0; bus_b = 8'h00;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_pres[k] = 1'b0;
         for (int j = 0; j < 4; j++) m_slot[k][j] = 8'h00;
      end
      cycle();
      cycle();
      chk("reset_valid_a", int'(ov_a), 0);
      chk("reset_count_a", int'(fc_a), 0);
      chk("reset_ready_a", int'(ir_a), 1);
      chk("reset_bus_a", int'(pack_a()), 0);
      chk("reset_valid_b", int'(ov_b), 0);
      reset = 1'b0;

      // Directed table: fill, hold under backpressure, refill, reset mid-group.
      for (int i = 0; i < 17; i++) begin
         reset = tbl[i].rst; iv_a = tbl[i].iv; bus_a = tbl[i].d; or_a = tbl[i].ordy;
         cycle();
         chk($sformatf("tbl%0d_valid", i), int'(ov_a), int'(tbl[i].ev));
         chk($sformatf("tbl%0d_count", i), int'(fc_a), tbl[i].ec);
         chk($sformatf("tbl%0d_ready", i), int'(ir_a), int'(tbl[i].eir));
         chk($sformatf("tbl%0d_bus", i), int'(pack_a()), int'(tbl[i].eb));
      end
      reset = 1'b0; iv_a = 1'b0; or_a = 1'b0;

      // Streaming: 12 back-to-back words with out_ready held high.
      got.delete(); hs_cyc.delete(); sent.delete();
      or_a = 1'b1;
      for (int w = 0; w < 12; w++) begin
         iv_a = 1'b1; bus_a = 8'($urandom); sent.push_back(bus_a);
         cycle();
      end
      iv_a = 1'b0;
      cycle();
      chk("stream_words", got.size(), 12);
      chk("stream_groups", hs_cyc.size(), 3);
      for (int j = 0; j < 12 && j < got.size(); j++) chk($sformatf("stream_word%0d", j), int'(got[j]), int'(sent[j]));
      for (int g = 1; g < hs_cyc.size(); g++) chk($sformatf("stream_gap%0d", g), hs_cyc[g] - hs_cyc[g-1], 4);
      or_a = 1'b0;

`ifdef P_DESER_FLUSH_EN
      iv_a = 1'b1; bus_a = 8'hAA; cycle();
      bus_a = 8'hBB; cycle();
      iv_a = 1'b0; flush = 1'b1; cycle();
      flush = 1'b0;
      chk("flush_valid", int'(ov_a), 1);
      chk("flush_count", int'(fc_a), 2);
      chk("flush_bus", int'(pack_a()), 32'h0000_BBAA);
      or_a = 1'b1; cycle();
      or_a = 1'b0; flush = 1'b1; cycle();
      flush = 1'b0;
      chk("flush_empty_valid", int'(ov_a), 0);
      chk("flush_empty_count", int'(fc_a), 0);
      iv_a = 1'b1; bus_a = 8'hC1; cycle();
      bus_a = 8'hC2; flush = 1'b1; cycle();
      iv_a = 1'b0; flush = 1'b0;
      chk("flush_same_valid", int'(ov_a), 1);
      chk("flush_same_count", int'(fc_a), 2);
      chk("flush_same_bus", int'(pack_a()), 32'h0000_C2C1);
      or_a = 1'b1; cycle();
      or_a = 1'b0;
`endif

      // Single-slot instance: held, then refilled in the same cycle it leaves.
      iv_b = 1'b1; bus_b = 8'h5A; or_b = 1'b0; cycle();
      chk("nb1_valid", int'(ov_b), 1);
      chk("nb1_count", int'(fc_b), 1);
      chk("nb1_slot", int'(ob_b[0]), 8'h5A);
      chk("nb1_ready_blocked", int'(ir_b), 0);
      bus_b = 8'h5B; or_b = 1'b1; cycle();
      chk("nb1_refill_valid", int'(ov_b), 1);
      chk("nb1_refill_slot", int'(ob_b[0]), 8'h5B);
      for (int w = 0; w < 3; w++) begin
         bus_b = 8'(8'h60 + w); cycle();
         chk($sformatf("nb1_stream%0d", w), int'(ob_b[0]), 8'h60 + w);
         chk($sformatf("nb1_ready%0d", w), int'(ir_b), 1);
      end
      iv_b = 1'b0; cycle();
      chk("nb1_drained", int'(ov_b), 0);
      or_b = 1'b0;

      // Randomised traffic on both instances against the model.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 40) == 0);
         iv_a  = 1'($urandom); or_a = 1'($urandom); bus_a = 8'($urandom);
         iv_b  = 1'($urandom); or_b = 1'($urandom); bus_b = 8'($urandom);
`ifdef P_DESER_FLUSH_EN
         flush = ($urandom_range(0, 7) == 0);
`endif
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
